mem_traffic_gen: RTL and testbench



---
 rtl/mem_tg_pkg.sv | 24 ++
 rtl/mem_traffic_gen_if.sv | 22 ++
 rtl/mem_tg_lfsr.sv | 29 ++
 rtl/mem_traffic_gen.sv | 205 ++++++++++++++++++++
 tb/tb_mem_traffic_gen.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_tg_pkg.sv
// Shared types and constants for the mem_traffic_gen bus master:
// FSM states, LFSR polynomial, MODE encodings and the LFSR step function.
package mem_tg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        DRAIN,
        DONE
    } tg_state_e;

    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    localparam int MODE_IDLE  = 0;
    localparam int MODE_WR_RD = 1;
    localparam int MODE_RD    = 2;

    // 32-bit Galois LFSR, shifting right; the polynomial is folded in when the bit shifted out is 1.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/mem_traffic_gen_if.sv
// MemSplit32 single-port bus: split request/response with in-order read data.
// The master holds a request stable until ack; read data returns later on resp.
interface MemSplit32;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;

    modport Master (
        output req, we, addr, wdata, be,
        input  ack, resp, rdata
    );

    modport Slave (
        input  req, we, addr, wdata, be,
        output ack, resp, rdata
    );
endinterface

// File: rtl/mem_tg_lfsr.sv
// Loadable 32-bit Galois LFSR used both to generate write data and to
// regenerate the expected read data.
module mem_tg_lfsr
    import mem_tg_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [31:0] seed_i,
    output logic [31:0] q_o
);

    logic [31:0] state_q;

    // Load takes priority so a restart always begins from the seed.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= '0;
        end else if (load_i) begin
            state_q <= seed_i;
        end else if (step_i) begin
            state_q <= lfsr_next(state_q);
        end
    end

    assign q_o = state_q;

endmodule

// File: rtl/mem_traffic_gen.sv
// Self-checking MemSplit32 traffic generator: write phase and/or read phase with LFSR data.
// Define MEM_TG_CHECK_EN to include read-data checking (checker LFSR, comparator, err_count_o).
module mem_traffic_gen
    import mem_tg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0,
    parameter int          NUM_TXN         = 16,
    parameter int          MODE            = MODE_WR_RD,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [31:0] SEED            = 32'h1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] err_count_o,
    MemSplit32.Master   mem
);

    if (SEED == 32'h0) begin : g_bad_seed
        $error("mem_traffic_gen: SEED must be nonzero");
    end
    if (NUM_TXN < 1 || NUM_TXN > 65535) begin : g_bad_num
        $error("mem_traffic_gen: NUM_TXN out of range 1..65535");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_max
        $error("mem_traffic_gen: MAX_OUTSTANDING out of range 1..15");
    end
    if (MODE < MODE_IDLE || MODE > MODE_RD) begin : g_bad_mode
        $error("mem_traffic_gen: MODE must be 0, 1 or 2");
    end

    localparam logic [15:0] LAST_IDX = 16'(NUM_TXN - 1);
    localparam logic [3:0]  MAX_OUT  = 4'(MAX_OUTSTANDING);

    tg_state_e   state;
    logic [15:0] idx;
    logic [3:0]  outstanding;
    logic [3:0]  out_next;
    logic        started;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [15:0] err_cnt_q;

    logic        start_ok;
    logic        xfer;
    logic        rd_xfer;
    logic        resp_ok;
    logic        resp_err;
    logic        mismatch;
    logic        gen_load;
    logic        gen_step;
    logic [31:0] gen_q;

    assign start_ok = start_i && (state == IDLE || state == DONE);
    assign xfer     = req_q && mem.ack;
    assign rd_xfer  = xfer && !we_q;
    assign resp_ok  = mem.resp && (outstanding != 4'd0);
    // Stale responses from before a reset are ignored until a sequence has been started.
    assign resp_err = mem.resp && (outstanding == 4'd0) && started;

    assign gen_load = start_ok || (state == WR && xfer && idx == LAST_IDX);
    assign gen_step = (state == WR) && xfer;

    mem_tg_lfsr u_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (gen_load),
        .step_i (gen_step),
        .seed_i (SEED),
        .q_o    (gen_q)
    );

`ifdef MEM_TG_CHECK_EN
    logic [31:0] chk_q;

    mem_tg_lfsr u_chk (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (start_ok),
        .step_i (resp_ok),
        .seed_i (SEED),
        .q_o    (chk_q)
    );

    assign mismatch = resp_ok && (mem.rdata != chk_q);
`else
    assign mismatch = 1'b0;
`endif

    // A read issued and a response retired in the same cycle cancel out.
    always_comb begin
        out_next = outstanding;
        if (rd_xfer && !resp_ok) begin
            out_next = outstanding + 4'd1;
        end else if (!rd_xfer && resp_ok) begin
            out_next = outstanding - 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            idx         <= '0;
            outstanding <= '0;
            started     <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            outstanding <= out_next;
            if (start_ok) begin
                started   <= 1'b1;
                idx       <= '0;
                addr_q    <= BASE_ADDR;
                err_q     <= 1'b0;
                err_cnt_q <= '0;
                done_q    <= 1'b0;
                if (MODE == MODE_WR_RD) begin
                    state  <= WR;
                    req_q  <= 1'b1;
                    we_q   <= 1'b1;
                    be_q   <= 4'hF;
                    busy_q <= 1'b1;
                end else if (MODE == MODE_RD) begin
                    state  <= RD;
                    req_q  <= 1'b1;
                    we_q   <= 1'b0;
                    be_q   <= 4'hF;
                    busy_q <= 1'b1;
                end else begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
            end else begin
                unique case (state)
                    WR: begin
                        if (xfer) begin
                            if (idx == LAST_IDX) begin
                                state  <= RD;
                                idx    <= '0;
                                addr_q <= BASE_ADDR;
                                we_q   <= 1'b0;
                            end else begin
                                idx    <= idx + 16'd1;
                                addr_q <= addr_q + 32'd4;
                            end
                        end
                    end
                    RD: begin
                        if (xfer) begin
                            if (idx == LAST_IDX) begin
                                state <= DRAIN;
                                req_q <= 1'b0;
                            end else begin
                                idx    <= idx + 16'd1;
                                addr_q <= addr_q + 32'd4;
                                req_q  <= (out_next < MAX_OUT);
                            end
                        end else if (!req_q) begin
                            req_q <= (out_next < MAX_OUT);
                        end
                    end
                    DRAIN: begin
                        if (out_next == 4'd0) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (resp_err || mismatch) begin
                    err_q <= 1'b1;
                end
                if (mismatch && err_cnt_q != 16'hFFFF) begin
                    err_cnt_q <= err_cnt_q + 16'd1;
                end
            end
        end
    end

    assign mem.req     = req_q;
    assign mem.we      = we_q;
    assign mem.addr    = addr_q;
    assign mem.wdata   = gen_q;
    assign mem.be      = be_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_mem_traffic_gen.sv
// Directed bench for mem_traffic_gen: a write/read-back instance and a read-only instance,
// each driven by a small memory model with configurable ack and response latency.
module tb_mem_traffic_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start_a = 1'b0, start_b = 1'b0;
    logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [15:0] errc_a, errc_b;

    MemSplit32 bus_a();
    MemSplit32 bus_b();

    mem_traffic_gen #(.BASE_ADDR(32'h1000), .NUM_TXN(4), .MODE(1), .MAX_OUTSTANDING(4), .SEED(32'h1)) u_dut_a (
        .clk_i(clk), .rst_i(rst_n), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
        .err_o(err_a), .err_count_o(errc_a), .mem(bus_a));

    mem_traffic_gen #(.BASE_ADDR(32'h0), .NUM_TXN(16), .MODE(2), .MAX_OUTSTANDING(2), .SEED(32'h1)) u_dut_b (
        .clk_i(clk), .rst_i(rst_n), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
        .err_o(err_b), .err_count_o(errc_b), .mem(bus_b));

`ifdef MEM_TG_CHECK_EN
    localparam logic        EXP_CORRUPT_ERR = 1'b1;
    localparam logic [15:0] EXP_CORRUPT_CNT = 16'd1;
`else
    localparam logic        EXP_CORRUPT_ERR = 1'b0;
    localparam logic [15:0] EXP_CORRUPT_CNT = 16'd0;
`endif

    // Write data for seed 1: 1, 80200003, C0300002, 60180001.
    logic [31:0] exp_wdata [4] = '{32'h00000001, 32'h80200003, 32'hC0300002, 32'h60180001};

    function automatic logic [31:0] model_lfsr(input logic [31:0] s);
        model_lfsr = s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    // Memory model A: word memory, optional read corruption, variable response latency.
    logic        ack_en_a = 1'b1;
    int          lat_a = 1;
    int          corrupt_a = -1;
    bit          spur_a = 1'b0;
    int          rd_cnt_a = 0;
    logic [31:0] mem_a [4];
    logic [31:0] q_data_a[$];
    int          q_due_a[$];
    logic [31:0] wr_addr_a[$], wr_data_a[$], rd_addr_a[$];

    assign bus_a.ack = ack_en_a;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_a.resp  <= 1'b0;
            bus_a.rdata <= '0;
            q_data_a.delete();
            q_due_a.delete();
        end else begin
            bus_a.resp <= 1'b0;
            if (bus_a.req && bus_a.ack) begin
                if (bus_a.we) begin
                    mem_a[bus_a.addr[3:2]] = bus_a.wdata;
                    wr_addr_a.push_back(bus_a.addr);
                    wr_data_a.push_back(bus_a.wdata);
                end else begin
                    logic [31:0] d;
                    d = mem_a[bus_a.addr[3:2]];
                    if (rd_cnt_a == corrupt_a) d = d ^ 32'h1;
                    rd_cnt_a++;
                    rd_addr_a.push_back(bus_a.addr);
                    q_data_a.push_back(d);
                    q_due_a.push_back(cyc + lat_a);
                end
            end
            if (spur_a) begin
                bus_a.resp <= 1'b1;
                spur_a = 1'b0;
            end else if (q_due_a.size() > 0 && q_due_a[0] <= cyc + 1) begin
                bus_a.resp  <= 1'b1;
                bus_a.rdata <= q_data_a.pop_front();
                void'(q_due_a.pop_front());
            end
        end
    end

    // Memory model B: preloaded with the seed-1 sequence, 10-cycle latency, outstanding tracker.
    logic [31:0] mem_b [16];
    logic [31:0] q_data_b[$];
    int          q_due_b[$];
    logic [31:0] rd_addr_b[$];
    int          out_b = 0, max_out_b = 0, viol_b = 0, resp_cnt_b = 0;

    assign bus_b.ack = 1'b1;

    initial begin
        logic [31:0] v;
        v = 32'h1;
        for (int i = 0; i < 16; i++) begin
            mem_b[i] = v;
            v = model_lfsr(v);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_b.resp  <= 1'b0;
            bus_b.rdata <= '0;
            q_data_b.delete();
            q_due_b.delete();
            out_b = 0;
        end else begin
            if (bus_b.req && out_b >= 2) viol_b++;
            if (bus_b.resp) resp_cnt_b++;
            out_b = out_b + ((bus_b.req && bus_b.ack && !bus_b.we) ? 1 : 0) - (bus_b.resp ? 1 : 0);
            if (out_b > max_out_b) max_out_b = out_b;
            bus_b.resp <= 1'b0;
            if (bus_b.req && bus_b.ack && !bus_b.we) begin
                rd_addr_b.push_back(bus_b.addr);
                q_data_b.push_back(mem_b[bus_b.addr[5:2]]);
                q_due_b.push_back(cyc + 10);
            end
            if (q_due_b.size() > 0 && q_due_b[0] <= cyc + 1) begin
                bus_b.resp  <= 1'b1;
                bus_b.rdata <= q_data_b.pop_front();
                void'(q_due_b.pop_front());
            end
        end
    end

    task automatic applyStimulus_start_a();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic clear_logs_a();
        wr_addr_a.delete();
        wr_data_a.delete();
        rd_addr_a.delete();
        rd_cnt_a = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy_a, done_a, err_a, errc_a} !== 19'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_status_a: got %h expected 0", {busy_a, done_a, err_a, errc_a});
        end
        tests_run++;
        if ({bus_a.req, bus_a.we, bus_a.addr, bus_a.wdata, bus_a.be} !== 70'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_bus_a: got %h expected 0", {bus_a.req, bus_a.we, bus_a.addr, bus_a.wdata, bus_a.be});
        end
        tests_run++;
        if ({busy_b, done_b, err_b, errc_b, bus_b.req} !== 20'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_b: got %h expected 0", {busy_b, done_b, err_b, errc_b, bus_b.req});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_wr_rd();
        clear_logs_a();
        lat_a = 1;
        corrupt_a = -1;
        applyStimulus_start_a();
        tests_run++;
        if ({bus_a.req, bus_a.we, bus_a.be, busy_a} !== 7'b1_1_1111_1 || bus_a.addr !== 32'h1000 || bus_a.wdata !== 32'h1) begin
            tests_failed++;
            $display("[TB] FAIL first_req: req/we/be/busy=%b addr=%h wdata=%h expected 1111111 00001000 00000001",
                     {bus_a.req, bus_a.we, bus_a.be, busy_a}, bus_a.addr, bus_a.wdata);
        end
        repeat (8) @(negedge clk);
        tests_run++;
        if (done_a !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL done_early: got %b expected 0", done_a);
        end
        @(negedge clk);
        tests_run++;
        if (done_a !== 1'b1 || busy_a !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL done_min_latency: done=%b busy=%b expected done=1 busy=0", done_a, busy_a);
        end
        tests_run++;
        if (wr_addr_a.size() != 4 || rd_addr_a.size() != 4) begin
            tests_failed++;
            $display("[TB] FAIL txn_count: writes=%0d reads=%0d expected 4 and 4", wr_addr_a.size(), rd_addr_a.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (wr_addr_a[i] !== 32'h1000 + 32'(4 * i) || wr_data_a[i] !== exp_wdata[i] || rd_addr_a[i] !== 32'h1000 + 32'(4 * i)) begin
                    tests_failed++;
                    $display("[TB] FAIL txn_%0d: waddr=%h wdata=%h raddr=%h expected addr=%h data=%h",
                             i, wr_addr_a[i], wr_data_a[i], rd_addr_a[i], 32'h1000 + 32'(4 * i), exp_wdata[i]);
                end
            end
        end
        tests_run++;
        if (err_a !== 1'b0 || errc_a !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL basic_err: err=%b count=%0d expected 0 0", err_a, errc_a);
        end
    endtask

    task automatic test_corrupt_read();
        int n;
        clear_logs_a();
        corrupt_a = 2;
        applyStimulus_start_a();
        n = 0;
        while (!done_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        corrupt_a = -1;
        tests_run++;
        if (done_a !== 1'b1 || err_a !== EXP_CORRUPT_ERR || errc_a !== EXP_CORRUPT_CNT) begin
            tests_failed++;
            $display("[TB] FAIL corrupt_read: done=%b err=%b count=%0d expected 1 %b %0d",
                     done_a, err_a, errc_a, EXP_CORRUPT_ERR, EXP_CORRUPT_CNT);
        end
    endtask

    task automatic test_wr_stall();
        int n;
        clear_logs_a();
        applyStimulus_start_a();
        @(negedge clk);
        ack_en_a = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests_run++;
            if (bus_a.req !== 1'b1 || bus_a.we !== 1'b1 || bus_a.addr !== 32'h1004 || bus_a.wdata !== 32'h80200003) begin
                tests_failed++;
                $display("[TB] FAIL stall_hold_%0d: req=%b we=%b addr=%h wdata=%h expected 1 1 00001004 80200003",
                         c, bus_a.req, bus_a.we, bus_a.addr, bus_a.wdata);
            end
        end
        ack_en_a = 1'b1;
        n = 0;
        while (!done_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (done_a !== 1'b1 || wr_addr_a.size() != 4) begin
            tests_failed++;
            $display("[TB] FAIL stall_done: done=%b writes=%0d expected 1 4", done_a, wr_addr_a.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (wr_addr_a[i] !== 32'h1000 + 32'(4 * i) || wr_data_a[i] !== exp_wdata[i]) begin
                    tests_failed++;
                    $display("[TB] FAIL stall_wr_%0d: addr=%h data=%h expected %h %h",
                             i, wr_addr_a[i], wr_data_a[i], 32'h1000 + 32'(4 * i), exp_wdata[i]);
                end
            end
        end
    endtask

    task automatic test_spurious_resp();
        @(negedge clk);
        spur_a = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (err_a !== 1'b1 || errc_a !== 16'd0 || done_a !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL spurious_resp: err=%b count=%0d done=%b expected 1 0 1", err_a, errc_a, done_a);
        end
    endtask

    task automatic test_read_only();
        int n;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 1000) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (done_b !== 1'b1 || resp_cnt_b != 16 || out_b != 0) begin
            tests_failed++;
            $display("[TB] FAIL rd_only_done: done=%b resps=%0d outstanding=%0d expected 1 16 0", done_b, resp_cnt_b, out_b);
        end
        tests_run++;
        if (viol_b != 0 || max_out_b != 2) begin
            tests_failed++;
            $display("[TB] FAIL rd_only_limit: violations=%0d peak=%0d expected 0 2", viol_b, max_out_b);
        end
        tests_run++;
        if (err_b !== 1'b0 || errc_b !== 16'd0 || rd_addr_b.size() != 16 || rd_addr_b[15] !== 32'h3C) begin
            tests_failed++;
            $display("[TB] FAIL rd_only_data: err=%b count=%0d reads=%0d expected 0 0 16", err_b, errc_b, rd_addr_b.size());
        end
    endtask

    task automatic test_reset_mid_read();
        int n;
        clear_logs_a();
        lat_a = 20;
        applyStimulus_start_a();
        n = 0;
        while (rd_addr_a.size() < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (rd_addr_a.size() != 3 || busy_a !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_setup: reads=%0d busy=%b expected 3 1", rd_addr_a.size(), busy_a);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy_a, done_a, err_a, errc_a, bus_a.req, bus_a.we, bus_a.addr, bus_a.be} !== 57'h0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_async: got %h expected 0",
                     {busy_a, done_a, err_a, errc_a, bus_a.req, bus_a.we, bus_a.addr, bus_a.be});
        end
        @(negedge clk);
        rst_n = 1'b1;
        lat_a = 1;
        clear_logs_a();
        applyStimulus_start_a();
        n = 0;
        while (!done_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (done_a !== 1'b1 || err_a !== 1'b0 || errc_a !== 16'd0 || wr_addr_a.size() != 4 || rd_addr_a.size() != 4) begin
            tests_failed++;
            $display("[TB] FAIL restart_clean: done=%b err=%b count=%0d writes=%0d reads=%0d expected 1 0 0 4 4",
                     done_a, err_a, errc_a, wr_addr_a.size(), rd_addr_a.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_wr_rd();
        test_corrupt_read();
        test_wr_stall();
        test_spurious_resp();
        test_read_only();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
